// File: rtl/idct_transpose4.sv
// 4x4 ping-pong transpose between IDCT row and column passes; one row in, one column out per cycle.
// Optional IDCT_TP_CLIP_EN saturates stored samples to signed 16-bit range.
module idct_transpose4 #(
  parameter int W = 25
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] d_in_1,
  input  logic [W-1:0] d_in_2,
  input  logic [W-1:0] d_in_3,
  input  logic [W-1:0] d_in_4,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] d_out_1,
  output logic [W-1:0] d_out_2,
  output logic [W-1:0] d_out_3,
  output logic [W-1:0] d_out_4,
  output logic         out_last
);

`ifdef IDCT_TP_CLIP_EN
  localparam logic signed [W-1:0] SAT_HI = {{(W-15){1'b0}}, 15'h7fff};
  localparam logic signed [W-1:0] SAT_LO = {{(W-15){1'b1}}, 15'h0000};

  function automatic logic [W-1:0] store_val(input logic [W-1:0] x);
    if ($signed(x) > SAT_HI) return SAT_HI;
    else if ($signed(x) < SAT_LO) return SAT_LO;
    else return x;
  endfunction
`else
  function automatic logic [W-1:0] store_val(input logic [W-1:0] x);
    return x;
  endfunction
`endif

  logic [W-1:0] mem_q [2][4][4];
  logic [W-1:0] mem_d [2][4][4];
  logic [1:0]   full_q, full_d;
  logic         wr_bank_q, wr_bank_d;
  logic         rd_bank_q, rd_bank_d;
  logic [1:0]   wr_row_q, wr_row_d;
  logic [1:0]   rd_col_q, rd_col_d;

  logic [W-1:0] d_in [4];
  logic         wr_acc;
  logic         rd_acc;

  assign d_in[0] = d_in_1;
  assign d_in[1] = d_in_2;
  assign d_in[2] = d_in_3;
  assign d_in[3] = d_in_4;

  assign in_ready  = !full_q[wr_bank_q];
  assign out_valid = full_q[rd_bank_q];
  assign out_last  = out_valid && (rd_col_q == 2'd3);
  assign wr_acc    = in_valid && in_ready;
  assign rd_acc    = out_valid && out_ready;

  assign d_out_1 = mem_q[rd_bank_q][0][rd_col_q];
  assign d_out_2 = mem_q[rd_bank_q][1][rd_col_q];
  assign d_out_3 = mem_q[rd_bank_q][2][rd_col_q];
  assign d_out_4 = mem_q[rd_bank_q][3][rd_col_q];

  // Write and read always target different banks, so both flag updates can land together.
  always_comb begin
    mem_d     = mem_q;
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_row_d  = wr_row_q;
    rd_col_d  = rd_col_q;

    if (wr_acc) begin
      for (int c = 0; c < 4; c++) begin
        mem_d[wr_bank_q][wr_row_q][c] = store_val(d_in[c]);
      end
      wr_row_d = wr_row_q + 2'd1;
      if (wr_row_q == 2'd3) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = !wr_bank_q;
      end
    end

    if (rd_acc) begin
      rd_col_d = rd_col_q + 2'd1;
      if (rd_col_q == 2'd3) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = !rd_bank_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < 4; r++) begin
          for (int c = 0; c < 4; c++) begin
            mem_q[b][r][c] <= '0;
          end
        end
      end
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_row_q  <= '0;
      rd_col_q  <= '0;
    end else begin
      mem_q     <= mem_d;
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_row_q  <= wr_row_d;
      rd_col_q  <= rd_col_d;
    end
  end

endmodule

// File: tb/tb_idct_transpose4.sv
// Bench for idct_transpose4: table vectors, hand sequences, and a column scoreboard.
module tb_idct_transpose4;
  localparam int W = 25;

  typedef logic [3:0][W-1:0] quad_t;
  typedef struct {
    quad_t row;
    quad_t col;
  } vec_t;
  typedef struct {
    quad_t d;
    logic  last;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] d_in_1, d_in_2, d_in_3, d_in_4;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] d_out_1, d_out_2, d_out_3, d_out_4;
  logic         out_last;

  int    n_cmp = 0;
  int    n_err = 0;
  exp_t  exp_q[$];
  quad_t part_q[$];

  idct_transpose4 #(.W(W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .d_in_1(d_in_1), .d_in_2(d_in_2), .d_in_3(d_in_3), .d_in_4(d_in_4),
    .out_valid(out_valid), .out_ready(out_ready),
    .d_out_1(d_out_1), .d_out_2(d_out_2), .d_out_3(d_out_3), .d_out_4(d_out_4),
    .out_last(out_last)
  );

  always #5 clk = ~clk;

  function automatic logic [4*W-1:0] cat4(input quad_t v);
    return {v[0], v[1], v[2], v[3]};
  endfunction

  function automatic logic [4*W-1:0] dout_cat();
    return {d_out_1, d_out_2, d_out_3, d_out_4};
  endfunction

  function automatic quad_t mkrow(input int k);
    quad_t r;
    for (int j = 0; j < 4; j++) r[j] = W'(k * 4 + j + 1);
    return r;
  endfunction

  function automatic logic [W-1:0] model_store(input logic [W-1:0] x);
`ifdef IDCT_TP_CLIP_EN
    if ($signed(x) > $signed(25'sd32767)) return 25'sd32767;
    if ($signed(x) < $signed(-25'sd32768)) return -25'sd32768;
`endif
    return x;
  endfunction

  task automatic check(input string name, input logic [4*W-1:0] act, input logic [4*W-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Samples handshakes mid-cycle; inputs are only changed just after the rising edge.
  task automatic monitor();
    exp_t  e;
    quad_t col;
    if (reset) begin
      part_q.delete();
      exp_q.delete();
      return;
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_unexpected: got column %h, required none", dout_cat());
      end else begin
        e = exp_q.pop_front();
        check("sb_col", dout_cat(), cat4(e.d));
        check("sb_last", {{(4*W-1){1'b0}}, out_last}, {{(4*W-1){1'b0}}, e.last});
      end
    end
    if (in_valid && in_ready) begin
      col = '0;
      for (int j = 0; j < 4; j++) begin
        col[j] = (j == 0) ? model_store(d_in_1) : (j == 1) ? model_store(d_in_2) :
                 (j == 2) ? model_store(d_in_3) : model_store(d_in_4);
      end
      part_q.push_back(col);
      if (part_q.size() == 4) begin
        for (int c = 0; c < 4; c++) begin
          for (int r = 0; r < 4; r++) e.d[r] = part_q[r][c];
          e.last = (c == 3);
          exp_q.push_back(e);
        end
        part_q.delete();
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_row(input quad_t r);
    in_valid = 1'b1;
    d_in_1 = r[0];
    d_in_2 = r[1];
    d_in_3 = r[2];
    d_in_4 = r[3];
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic check_b(input string name, input logic act, input logic req);
    check(name, {{(4*W-1){1'b0}}, act}, {{(4*W-1){1'b0}}, req});
  endtask

  vec_t         v1[4];
  quad_t        r5[4];
  logic [W-1:0] e5[4];
  logic [W-1:0] e6[4];

  initial begin
    for (int i = 0; i < 4; i++) begin
      v1[i].row = mkrow(i);
      for (int r = 0; r < 4; r++) v1[i].col[r] = W'(r * 4 + i + 1);
    end
    r5[0] = {-25'sd5, 25'sd32767, -25'sd40000, 25'sd40000};
    r5[1] = {25'h1FFFFFF, 25'h0000000, 25'h1000000, 25'h0FFFFFF};
    r5[2] = mkrow(0);
    r5[3] = mkrow(1);
`ifdef IDCT_TP_CLIP_EN
    e5 = '{25'sd32767, -25'sd32768, 25'sd32767, -25'sd5};
    e6 = '{25'sd32767, -25'sd32768, 25'h0000000, 25'h1FFFFFF};
`else
    e5 = '{25'sd40000, -25'sd40000, 25'sd32767, -25'sd5};
    e6 = '{25'h0FFFFFF, 25'h1000000, 25'h0000000, 25'h1FFFFFF};
`endif

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    d_in_1 = '0; d_in_2 = '0; d_in_3 = '0; d_in_4 = '0;
    @(posedge clk); #1;
    tick();
    check_b("rst_in_ready", in_ready, 1'b1);
    check_b("rst_out_valid", out_valid, 1'b0);
    check_b("rst_out_last", out_last, 1'b0);
    check("rst_dout", dout_cat(), '0);
    reset = 1'b0;

    // Basic 4x4 transpose from the vector table.
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_row(v1[i].row);
      check_b("t1_no_early_valid", out_valid, 1'b0);
      tick();
    end
    in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check_b("t1_out_valid", out_valid, 1'b1);
      check("t1_col", dout_cat(), cat4(v1[c].col));
      check_b("t1_last", out_last, c == 3);
      tick();
    end
    check_b("t1_idle", out_valid, 1'b0);

    // Three blocks streamed back-to-back.
    for (int c = 0; c < 16; c++) begin
      if (c < 12) begin
        drive_row(mkrow(100 + c));
        check_b("t2_in_ready", in_ready, 1'b1);
      end else begin
        in_valid = 1'b0;
      end
      check_b("t2_out_valid", out_valid, c >= 4);
      tick();
    end
    check("t2_sb_empty", 4*W'(exp_q.size()), '0);

    // Consumer stall with both banks filled.
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      drive_row(mkrow(k));
      check_b("t3_in_ready_fill", in_ready, 1'b1);
      tick();
    end
    drive_row(mkrow(8));
    for (int s = 0; s < 3; s++) begin
      check_b("t3_in_ready_full", in_ready, 1'b0);
      check("t3_hold", dout_cat(), cat4(v1[0].col));
      tick();
    end
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      check_b("t3_in_ready_drain", in_ready, 1'b0);
      tick();
    end
    check_b("t3_in_ready_back", in_ready, 1'b1);
    tick();
    for (int k = 9; k < 12; k++) begin
      drive_row(mkrow(k));
      tick();
    end
    in_valid = 1'b0;
    for (int s = 0; s < 10; s++) tick();
    check("t3_sb_empty", 4*W'(exp_q.size()), '0);

    // Reset after a partial write, and again mid-read.
    out_ready = 1'b0;
    drive_row(v1[0].row); tick();
    drive_row(v1[1].row); tick();
    do_reset();
    check_b("t4a_out_valid", out_valid, 1'b0);
    check_b("t4a_in_ready", in_ready, 1'b1);
    check("t4a_dout", dout_cat(), '0);
    for (int i = 0; i < 4; i++) begin
      drive_row(v1[i].row);
      tick();
    end
    in_valid = 1'b0;
    check_b("t4b_full", out_valid, 1'b1);
    out_ready = 1'b1;
    tick();
    tick();
    do_reset();
    check_b("t4b_out_valid", out_valid, 1'b0);
    check_b("t4b_in_ready", in_ready, 1'b1);
    check_b("t4b_out_last", out_last, 1'b0);
    check("t4b_dout", dout_cat(), '0);
    for (int i = 0; i < 4; i++) begin
      drive_row(mkrow(40 + i));
      tick();
    end
    in_valid = 1'b0;
    check_b("t4c_valid", out_valid, 1'b1);
    for (int s = 0; s < 4; s++) tick();
    check("t4c_sb_empty", 4*W'(exp_q.size()), '0);

    // Clipping / signed extremes.
    for (int i = 0; i < 4; i++) begin
      drive_row(r5[i]);
      tick();
    end
    in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check("t5_dout1", {{(3*W){1'b0}}, d_out_1}, {{(3*W){1'b0}}, e5[c]});
      check("t6_dout2", {{(3*W){1'b0}}, d_out_2}, {{(3*W){1'b0}}, e6[c]});
      tick();
    end
    check("t5_sb_empty", 4*W'(exp_q.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
